guarded_fp_rr_arbiter: RTL and testbench
========================================

Name: guarded_fp_rr_arbiter

Overview:
- Shares one egress link between one high-priority time-triggered (TT) queue server and N low-priority queue servers (RC/BE) using the ready/go/ena_n handshake.
- H wins whenever ready. L requesters are served round-robin, but only if the packet fits before the next TT window opens (guard-band check against the timetable countdown).
- Sits between the queue servers and the link; replaces ad-hoc fixed-priority round robin where TT windows must never be intruded on.

Parameters:
- N, 3, number of low-priority requesters (1..8).
- LEN_W, 8, width of pkt_len and gap values.
- GUARD, 2, extra idle cycles required between L packet end and TT window start.
- GO_TIMEOUT, 4, cycles a granted requester may take to raise bool_go before the grant is revoked.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- bool_ready_H  in  1  TT server has a packet.
- bool_go_H  in  1  TT server transmitting.
- bool_ready_L  in  N  L servers have a packet.
- bool_go_L  in  N  L servers transmitting.
- pkt_len_L  in  N*LEN_W  packed packet length in cycles per L server; slice i = [i*LEN_W +: LEN_W].
- tt_gap  in  LEN_W  cycles until next TT window opens.
- tt_gap_valid  in  1  0 = no TT window scheduled, so the guard check is bypassed.
- ena_n_H  out  1  active-low grant to TT server.
- ena_n_L  out  N  active-low grants to L servers.
- active  out  2  00 none, 01 H, 10 L.
- channel  out  4  index of granted L server, 0 when not L.
- timeout_err  out  1  one-cycle pulse when a grant is revoked on timeout.
- conflict_err  out  1  sticky; set if more than one bool_go is seen high in any cycle.

Behaviour:
- Reset (async, rst_n=0): ena_n_H=1, ena_n_L=all 1, active=00, channel=0, timeout_err=0, conflict_err=0, rr_ptr=0, state IDLE.
- All outputs are registered. Grant appears one cycle after the deciding edge.
- States:
  - IDLE: arbitration each cycle.
    - If bool_ready_H=1: go to GRANT_H, assert ena_n_H=0, active=01.
    - Else pick the first eligible L, searching from rr_ptr upward with wrap.
    - L index i is eligible if bool_ready_L[i]=1 and (tt_gap_valid=0 or pkt_len_L[i]+GUARD <= tt_gap).
    - The sum is computed LEN_W+1 bits wide; no wrap.
    - On a match: go to GRANT_L, ena_n_L[i]=0, active=10, channel=i.
    - No eligible requester: stay in IDLE.
  - GRANT_H / GRANT_L: count cycles waiting for the granted bool_go.
    - go=1: move to BUSY_H / BUSY_L.
    - Count reaches GO_TIMEOUT without go: release the grant, pulse timeout_err, return to IDLE. On an L timeout, rr_ptr advances past i.
  - BUSY_H / BUSY_L: hold the grant while go=1.
    - On go falling: release the grant (ena_n back to 1, active=00, channel=0) and go to IDLE.
    - For L, rr_ptr = (i+1) mod N.
- Release and new grant are never in the same cycle. There is at least one IDLE cycle between grants.
- A TT request arriving during BUSY_L is not preemptive. The guard check is what guarantees no overlap.
- A TT request arriving during GRANT_L with go not yet high: the L grant is withdrawn immediately and H is granted via IDLE. rr_ptr is not advanced.
- Simultaneous H and L ready in IDLE: H wins.
- rr_ptr advances only on a completed or timed-out L grant.
- Ready dropping while in GRANT: treated as a timeout path, released next cycle without a timeout_err pulse.
- conflict_err is sticky until reset.

Decomposition:
- Shared package holds:
  - active encodings ACT_NONE=2'b00, ACT_H=2'b01, ACT_L=2'b10.
  - the state enum.
  - the traffic class constants P_PCF/P_TT/P_RC/P_BE.
- One sub-module, rr_pick_eligible: combinational rotate-priority encoder (N, rr_ptr, eligible mask → found, index).

Test Plan:
1. Only bool_ready_L[1]=1, pkt_len=12, tt_gap_valid=0, server raises go 2 cycles after grant and holds it 12 cycles → ena_n_L[1]=0 for 15 cycles, channel=1, active=10, rr_ptr=2 afterwards.
2. H and L[0] ready in the same cycle → ena_n_H=0 next cycle, ena_n_L stays all 1; after H completes, L[0] is granted after one IDLE cycle.
3. L[0] pkt_len=24, tt_gap=20, GUARD=2 → no grant. L[1] pkt_len=12 → granted, since 14<=20.
4. All three L ready, each completes → grant order 0,1,2,0; starting rr_ptr=2 → order 2,0,1.
5. L[2] granted, go never rises → release after 4 cycles, timeout_err single pulse, next grant goes to L[0].
6. Force bool_go_H and bool_go_L[0] high together → conflict_err=1 and stays 1 until rst_n pulsed low mid-operation, which clears all outputs asynchronously.

Source files
------------

// File: rtl/guarded_fp_rr_arbiter_pkg.sv
// rtl/guarded_fp_rr_arbiter_pkg.sv - shared encodings for the guarded fixed-priority / round-robin arbiter
package guarded_fp_rr_arbiter_pkg;

    localparam logic [1:0] ACT_NONE = 2'b00;
    localparam logic [1:0] ACT_H    = 2'b01;
    localparam logic [1:0] ACT_L    = 2'b10;

    // Traffic classes carried by the queue servers feeding this arbiter
    localparam logic [1:0] P_PCF = 2'd0;
    localparam logic [1:0] P_TT  = 2'd1;
    localparam logic [1:0] P_RC  = 2'd2;
    localparam logic [1:0] P_BE  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GRANT_H = 3'd1,
        ST_GRANT_L = 3'd2,
        ST_BUSY_H  = 3'd3,
        ST_BUSY_L  = 3'd4
    } arb_state_t;

endpackage

// File: rtl/guarded_fp_rr_arbiter_rr_pick_eligible.sv
// rtl/guarded_fp_rr_arbiter_rr_pick_eligible.sv - rotate-priority encoder over an eligible mask
module rr_pick_eligible #(
    parameter int N     = 3,
    parameter int PTR_W = 2
) (
    input  logic [PTR_W-1:0] rr_ptr,
    input  logic [N-1:0]     eligible,
    output logic             found,
    output logic [PTR_W-1:0] index
);

    always_comb begin : pick
        int                 j;
        logic [PTR_W-1:0]   jj;
        found = 1'b0;
        index = '0;
        j     = 0;
        jj    = '0;
        // Search starts at rr_ptr and wraps, so the first hit is the round-robin winner
        for (int k = 0; k < N; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            jj = PTR_W'(j);
            if (!found && eligible[jj]) begin
                found = 1'b1;
                index = jj;
            end
        end
    end

endmodule

// File: rtl/guarded_fp_rr_arbiter.sv
// rtl/guarded_fp_rr_arbiter.sv - TT-first egress arbiter with guard-banded round-robin for RC/BE servers
module guarded_fp_rr_arbiter
    import guarded_fp_rr_arbiter_pkg::*;
#(
    parameter int N          = 3,
    parameter int LEN_W      = 8,
    parameter int GUARD      = 2,
    parameter int GO_TIMEOUT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               bool_ready_H,
    input  logic               bool_go_H,
    input  logic [N-1:0]       bool_ready_L,
    input  logic [N-1:0]       bool_go_L,
    input  logic [N*LEN_W-1:0] pkt_len_L,
    input  logic [LEN_W-1:0]   tt_gap,
    input  logic               tt_gap_valid,
    output logic               ena_n_H,
    output logic [N-1:0]       ena_n_L,
    output logic [1:0]         active,
    output logic [3:0]         channel,
    output logic               timeout_err,
    output logic               conflict_err
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;
    localparam int CNT_W = $clog2(GO_TIMEOUT + 1);
    localparam logic [LEN_W:0]   GUARD_EXT = (LEN_W + 1)'(GUARD);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(GO_TIMEOUT - 1);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(N - 1);

    arb_state_t       state, state_nxt;
    logic [CNT_W-1:0] wait_cnt, wait_nxt;
    logic [PTR_W-1:0] rr_ptr, ptr_nxt;
    logic [PTR_W-1:0] cur, cur_nxt;
    logic             ena_h_nxt;
    logic [N-1:0]     ena_l_nxt;
    logic [1:0]       active_nxt;
    logic [3:0]       channel_nxt;
    logic             tmo_nxt;
    logic             conflict_nxt;
    logic             rel_grant;
    logic             adv_ptr;

    logic [N-1:0]     eligible;
    logic             pick_found;
    logic [PTR_W-1:0] pick_idx;

    // Sum is one bit wider than the operands so a long packet can never wrap into "fits"
    always_comb begin : elig
        logic [LEN_W:0] need;
        need     = '0;
        eligible = '0;
        for (int i = 0; i < N; i++) begin
            need        = {1'b0, pkt_len_L[i*LEN_W +: LEN_W]} + GUARD_EXT;
            eligible[i] = bool_ready_L[i] && (!tt_gap_valid || (need <= {1'b0, tt_gap}));
        end
    end

    rr_pick_eligible #(
        .N     (N),
        .PTR_W (PTR_W)
    ) u_pick (
        .rr_ptr   (rr_ptr),
        .eligible (eligible),
        .found    (pick_found),
        .index    (pick_idx)
    );

    always_comb begin
        state_nxt    = state;
        wait_nxt     = wait_cnt;
        ptr_nxt      = rr_ptr;
        cur_nxt      = cur;
        ena_h_nxt    = ena_n_H;
        ena_l_nxt    = ena_n_L;
        active_nxt   = active;
        channel_nxt  = channel;
        tmo_nxt      = 1'b0;
        conflict_nxt = conflict_err | ($countones({bool_go_H, bool_go_L}) > 1);
        rel_grant    = 1'b0;
        adv_ptr      = 1'b0;

        case (state)
            ST_IDLE: begin
                wait_nxt = '0;
                if (bool_ready_H) begin
                    state_nxt  = ST_GRANT_H;
                    ena_h_nxt  = 1'b0;
                    active_nxt = ACT_H;
                end else if (pick_found) begin
                    state_nxt   = ST_GRANT_L;
                    cur_nxt     = pick_idx;
                    ena_l_nxt   = ~(N'(1) << pick_idx);
                    active_nxt  = ACT_L;
                    channel_nxt = 4'(pick_idx);
                end
            end
            ST_GRANT_H: begin
                if (bool_go_H) begin
                    state_nxt = ST_BUSY_H;
                end else if (!bool_ready_H) begin
                    rel_grant = 1'b1;
                end else if (wait_cnt == CNT_LAST) begin
                    rel_grant = 1'b1;
                    tmo_nxt   = 1'b1;
                end else begin
                    wait_nxt = wait_cnt + CNT_W'(1);
                end
            end
            ST_GRANT_L: begin
                // A pending TT request pulls back an L grant that has not started yet
                if (bool_go_L[cur]) begin
                    state_nxt = ST_BUSY_L;
                end else if (bool_ready_H) begin
                    rel_grant = 1'b1;
                end else if (!bool_ready_L[cur]) begin
                    rel_grant = 1'b1;
                    adv_ptr   = 1'b1;
                end else if (wait_cnt == CNT_LAST) begin
                    rel_grant = 1'b1;
                    adv_ptr   = 1'b1;
                    tmo_nxt   = 1'b1;
                end else begin
                    wait_nxt = wait_cnt + CNT_W'(1);
                end
            end
            ST_BUSY_H: begin
                if (!bool_go_H) begin
                    rel_grant = 1'b1;
                end
            end
            ST_BUSY_L: begin
                if (!bool_go_L[cur]) begin
                    rel_grant = 1'b1;
                    adv_ptr   = 1'b1;
                end
            end
            default: begin
                rel_grant = 1'b1;
            end
        endcase

        if (rel_grant) begin
            state_nxt   = ST_IDLE;
            ena_h_nxt   = 1'b1;
            ena_l_nxt   = '1;
            active_nxt  = ACT_NONE;
            channel_nxt = 4'd0;
        end
        if (adv_ptr) begin
            ptr_nxt = (cur == PTR_LAST) ? '0 : cur + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            wait_cnt     <= '0;
            rr_ptr       <= '0;
            cur          <= '0;
            ena_n_H      <= 1'b1;
            ena_n_L      <= '1;
            active       <= ACT_NONE;
            channel      <= 4'd0;
            timeout_err  <= 1'b0;
            conflict_err <= 1'b0;
        end else begin
            state        <= state_nxt;
            wait_cnt     <= wait_nxt;
            rr_ptr       <= ptr_nxt;
            cur          <= cur_nxt;
            ena_n_H      <= ena_h_nxt;
            ena_n_L      <= ena_l_nxt;
            active       <= active_nxt;
            channel      <= channel_nxt;
            timeout_err  <= tmo_nxt;
            conflict_err <= conflict_nxt;
        end
    end

endmodule

// File: tb/tb_guarded_fp_rr_arbiter.sv
// tb/tb_guarded_fp_rr_arbiter.sv - self-checking bench for guarded_fp_rr_arbiter
module tb_guarded_fp_rr_arbiter;

    localparam int N          = 3;
    localparam int LEN_W      = 8;
    localparam int GUARD      = 2;
    localparam int GO_TIMEOUT = 4;
    localparam int OWN_NONE   = -1;
    localparam int OWN_H      = N;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               bool_ready_H = 1'b0;
    logic               bool_go_H = 1'b0;
    logic [N-1:0]       bool_ready_L = '0;
    logic [N-1:0]       bool_go_L = '0;
    logic [N*LEN_W-1:0] pkt_len_L = '0;
    logic [LEN_W-1:0]   tt_gap = '0;
    logic               tt_gap_valid = 1'b0;
    logic               ena_n_H;
    logic [N-1:0]       ena_n_L;
    logic [1:0]         active;
    logic [3:0]         channel;
    logic               timeout_err;
    logic               conflict_err;

    guarded_fp_rr_arbiter #(
        .N(N), .LEN_W(LEN_W), .GUARD(GUARD), .GO_TIMEOUT(GO_TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .bool_ready_H(bool_ready_H), .bool_go_H(bool_go_H),
        .bool_ready_L(bool_ready_L), .bool_go_L(bool_go_L),
        .pkt_len_L(pkt_len_L), .tt_gap(tt_gap), .tt_gap_valid(tt_gap_valid),
        .ena_n_H(ena_n_H), .ena_n_L(ena_n_L), .active(active), .channel(channel),
        .timeout_err(timeout_err), .conflict_err(conflict_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: who owns the link, whether it started, missed go cycles, rr position
    int m_owner;
    bit m_started;
    int m_wait;
    int m_ptr;
    bit m_conf;
    bit m_tmo;

    typedef struct {
        logic       rh;
        logic [2:0] rl;
        logic [7:0] len0, len1, len2;
        logic [7:0] gap;
        logic       gv;
        logic [11:0] exp;
    } vec_t;
    vec_t tbl [12];

    function automatic logic [11:0] mk(input logic eh, input logic [2:0] el,
                                       input logic [1:0] act, input logic [3:0] ch);
        return {eh, el, act, ch, 2'b00};
    endfunction

    function automatic logic [11:0] outs();
        return {ena_n_H, ena_n_L, active, channel, timeout_err, conflict_err};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bool_ready_H = 1'b0;
        bool_go_H    = 1'b0;
        bool_ready_L = '0;
        bool_go_L    = '0;
        pkt_len_L    = '0;
        tt_gap       = '0;
        tt_gap_valid = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        m_owner = OWN_NONE; m_started = 0; m_wait = 0; m_ptr = 0; m_conf = 0; m_tmo = 0;
    endtask

    function automatic bit fits(input int i);
        return !tt_gap_valid ||
               (int'(pkt_len_L[i*LEN_W +: LEN_W]) + GUARD <= int'(tt_gap));
    endfunction

    task automatic model_step();
        bit go, rdy;
        int i;
        m_tmo = 0;
        if ($countones({bool_go_H, bool_go_L}) > 1) m_conf = 1;
        if (m_owner == OWN_NONE) begin
            if (bool_ready_H) begin
                m_owner = OWN_H; m_started = 0; m_wait = 0;
            end else begin
                for (int k = 0; k < N; k++) begin
                    i = (m_ptr + k) % N;
                    if (bool_ready_L[i] && fits(i)) begin
                        m_owner = i; m_started = 0; m_wait = 0;
                        break;
                    end
                end
            end
        end else begin
            go  = (m_owner == OWN_H) ? bool_go_H : bool_go_L[m_owner];
            rdy = (m_owner == OWN_H) ? bool_ready_H : bool_ready_L[m_owner];
            if (m_started) begin
                if (!go) begin
                    if (m_owner != OWN_H) m_ptr = (m_owner + 1) % N;
                    m_owner = OWN_NONE;
                end
            end else if (go) begin
                m_started = 1;
            end else if (m_owner != OWN_H && bool_ready_H) begin
                m_owner = OWN_NONE;
            end else begin
                if (rdy) m_wait++;
                if (!rdy || m_wait == GO_TIMEOUT) begin
                    m_tmo = rdy;
                    if (m_owner != OWN_H) m_ptr = (m_owner + 1) % N;
                    m_owner = OWN_NONE;
                end
            end
        end
    endtask

    function automatic logic [11:0] model_outs();
        logic [2:0] el;
        logic [1:0] act;
        logic [3:0] ch;
        el = 3'b111; act = 2'b00; ch = 4'd0;
        if (m_owner == OWN_H) act = 2'b01;
        else if (m_owner != OWN_NONE) begin
            el[m_owner] = 1'b0;
            act = 2'b10;
            ch = 4'(m_owner);
        end
        return {m_owner != OWN_H, el, act, ch, m_tmo, m_conf};
    endfunction

    task automatic serve_one(output int idx);
        idx = -1;
        for (int c = 0; c < 10 && idx < 0; c++) begin
            tick();
            for (int i = 0; i < N; i++) if (!ena_n_L[i]) idx = i;
        end
        if (idx >= 0) begin
            bool_go_L[idx] = 1'b1;
            tick();
            tick();
            bool_go_L[idx] = 1'b0;
            tick();
        end
    endtask

    initial begin
        int low, pulses, idx, r;
        int exp_order [4];

        tbl[0]  = '{1'b0, 3'b000, 8'd5,   8'd5,  8'd5, 8'd0,   1'b0, mk(1, 3'b111, 2'b00, 4'd0)};
        tbl[1]  = '{1'b1, 3'b000, 8'd5,   8'd5,  8'd5, 8'd0,   1'b0, mk(0, 3'b111, 2'b01, 4'd0)};
        tbl[2]  = '{1'b1, 3'b001, 8'd5,   8'd5,  8'd5, 8'd0,   1'b0, mk(0, 3'b111, 2'b01, 4'd0)};
        tbl[3]  = '{1'b0, 3'b010, 8'd5,   8'd12, 8'd5, 8'd0,   1'b0, mk(1, 3'b101, 2'b10, 4'd1)};
        tbl[4]  = '{1'b0, 3'b001, 8'd24,  8'd12, 8'd5, 8'd20,  1'b1, mk(1, 3'b111, 2'b00, 4'd0)};
        tbl[5]  = '{1'b0, 3'b011, 8'd24,  8'd12, 8'd5, 8'd20,  1'b1, mk(1, 3'b101, 2'b10, 4'd1)};
        tbl[6]  = '{1'b0, 3'b001, 8'd18,  8'd5,  8'd5, 8'd20,  1'b1, mk(1, 3'b110, 2'b10, 4'd0)};
        tbl[7]  = '{1'b0, 3'b001, 8'd19,  8'd5,  8'd5, 8'd20,  1'b1, mk(1, 3'b111, 2'b00, 4'd0)};
        tbl[8]  = '{1'b0, 3'b001, 8'd255, 8'd5,  8'd5, 8'd255, 1'b1, mk(1, 3'b111, 2'b00, 4'd0)};
        tbl[9]  = '{1'b0, 3'b001, 8'd255, 8'd5,  8'd5, 8'd255, 1'b0, mk(1, 3'b110, 2'b10, 4'd0)};
        tbl[10] = '{1'b0, 3'b100, 8'd5,   8'd5,  8'd5, 8'd0,   1'b0, mk(1, 3'b011, 2'b10, 4'd2)};
        tbl[11] = '{1'b0, 3'b111, 8'd5,   8'd5,  8'd5, 8'd0,   1'b0, mk(1, 3'b110, 2'b10, 4'd0)};

        do_reset();
        check("reset_state", outs(), mk(1, 3'b111, 2'b00, 4'd0));

        for (int v = 0; v < 12; v++) begin
            do_reset();
            bool_ready_H = tbl[v].rh;
            bool_ready_L = tbl[v].rl;
            pkt_len_L    = {tbl[v].len2, tbl[v].len1, tbl[v].len0};
            tt_gap       = tbl[v].gap;
            tt_gap_valid = tbl[v].gv;
            tick();
            check($sformatf("vec%0d", v), outs(), tbl[v].exp);
        end

        // L1 alone: 2-cycle go latency plus 12-cycle packet keeps the grant for 15 cycles
        do_reset();
        bool_ready_L = 3'b010;
        pkt_len_L    = {8'd12, 8'd12, 8'd12};
        tick();
        check("t1_grant", outs(), mk(1, 3'b101, 2'b10, 4'd1));
        low = 0;
        for (int c = 0; c < 30; c++) begin
            if (!ena_n_L[1]) low++;
            bool_go_L[1] = (c + 1 >= 3) && (c + 1 <= 14);
            if (c + 1 == 3) bool_ready_L = '0;
            tick();
        end
        check("t1_grant_cycles", low, 15);
        bool_ready_L = 3'b111;
        tick();
        check("t1_rr_ptr_2", outs(), mk(1, 3'b011, 2'b10, 4'd2));

        // H and L0 together: H first, one idle cycle, then L0
        do_reset();
        bool_ready_H = 1'b1;
        bool_ready_L = 3'b001;
        tick();
        check("t2_h_wins", outs(), mk(0, 3'b111, 2'b01, 4'd0));
        bool_go_H = 1'b1;
        bool_ready_H = 1'b0;
        tick();
        tick();
        bool_go_H = 1'b0;
        tick();
        check("t2_h_release", outs(), mk(1, 3'b111, 2'b00, 4'd0));
        tick();
        check("t2_l_after_h", outs(), mk(1, 3'b110, 2'b10, 4'd0));

        // Round-robin order from rr_ptr=0, then from rr_ptr=2
        do_reset();
        pkt_len_L = {8'd1, 8'd1, 8'd1};
        bool_ready_L = 3'b111;
        exp_order = '{0, 1, 2, 0};
        for (int k = 0; k < 4; k++) begin
            serve_one(idx);
            check($sformatf("t4_order_a%0d", k), idx, exp_order[k]);
        end
        do_reset();
        pkt_len_L = {8'd1, 8'd1, 8'd1};
        bool_ready_L = 3'b010;
        serve_one(idx);
        check("t4_prep", idx, 1);
        bool_ready_L = 3'b111;
        exp_order = '{2, 0, 1, 2};
        for (int k = 0; k < 3; k++) begin
            serve_one(idx);
            check($sformatf("t4_order_b%0d", k), idx, exp_order[k]);
        end

        // L2 granted with rr_ptr=2, never starts: revoked after GO_TIMEOUT cycles
        do_reset();
        pkt_len_L = {8'd1, 8'd1, 8'd1};
        bool_ready_L = 3'b010;
        serve_one(idx);
        bool_ready_L = 3'b100;
        tick();
        check("t5_grant_l2", outs(), mk(1, 3'b011, 2'b10, 4'd2));
        low = 1;
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (!ena_n_L[2]) low++;
            if (timeout_err) pulses++;
            if (ena_n_L == 3'b111) break;
        end
        check("t5_grant_cycles", low, GO_TIMEOUT);
        check("t5_tmo_pulses", pulses, 1);
        bool_ready_L = 3'b111;
        tick();
        check("t5_next_l0", outs(), mk(1, 3'b110, 2'b10, 4'd0));

        // Two gos at once: sticky conflict, cleared only by async reset
        do_reset();
        bool_go_H = 1'b1;
        bool_go_L = 3'b001;
        tick();
        check("t6_conflict_set", conflict_err, 1);
        bool_go_H = 1'b0;
        bool_go_L = '0;
        bool_ready_L = 3'b010;
        tick();
        check("t6_conflict_sticky", outs(), mk(1, 3'b101, 2'b10, 4'd1) | 12'b1);
        tick();
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_async_reset", outs(), mk(1, 3'b111, 2'b00, 4'd0));
        bool_ready_L = '0;
        tick();
        rst_n = 1'b1;

        // Randomized traffic against the reference model
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            bool_ready_H = (m_owner == OWN_H) ? ($urandom_range(0, 7) != 0)
                                              : ($urandom_range(0, 5) == 0);
            bool_ready_L = N'($urandom);
            for (int i = 0; i < N; i++) pkt_len_L[i*LEN_W +: LEN_W] = 8'($urandom_range(0, 30));
            tt_gap       = 8'($urandom_range(0, 40));
            tt_gap_valid = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 9) == 0) begin
                pkt_len_L[0 +: LEN_W] = 8'd255;
                tt_gap = 8'd255;
            end
            bool_go_H = 1'b0;
            bool_go_L = '0;
            if (m_owner == OWN_H)
                bool_go_H = m_started ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) == 0);
            else if (m_owner != OWN_NONE)
                bool_go_L[m_owner] = m_started ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) == 0);
            if ($urandom_range(0, 499) == 0) begin
                r = $urandom_range(0, N - 1);
                bool_go_L[r] = 1'b1;
            end
            model_step();
            tick();
            check($sformatf("rand_cycle%0d", c), outs(), model_outs());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1);
    end

endmodule
